// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply / restoring-divide unit with a start/busy/done handshake.
// Optional build macro MULDIV_ZERO_SKIP_EN: zero-operand multiplies bypass the iteration loop.
module ex_muldiv #(
  parameter int DATA_WID = 16,
  parameter int CNT_WID  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DATA_WID-1:0] srcdata_a,
  input  logic [DATA_WID-1:0] srcdata_b,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [DATA_WID-1:0] result_hi,
  output logic [DATA_WID-1:0] result_lo,
  output logic                div_zero
);

  localparam int W = DATA_WID;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t             state;
  logic [CNT_WID-1:0] cnt;
  logic [1:0]         op_q;
  logic [2*W-1:0]     acc;
  logic [W-1:0]       dvsr;
  logic               res_neg;
  logic               rem_neg;

  logic               a_neg, b_neg, b_zero;
  logic [W-1:0]       a_mag, b_mag;
  logic [W:0]         mul_sum, rem_shift, trial;
  logic [2*W-1:0]     calc_next, prod_neg;
  logic [W-1:0]       quo_neg, rem_neg_val, fix_hi, fix_lo;

  // Signed ops iterate on magnitudes; the signs are reapplied in FIXUP.
  always_comb begin
    a_neg  = op[0] & srcdata_a[W-1];
    b_neg  = op[0] & srcdata_b[W-1];
    a_mag  = a_neg ? (~srcdata_a + 1'b1) : srcdata_a;
    b_mag  = b_neg ? (~srcdata_b + 1'b1) : srcdata_b;
    b_zero = (srcdata_b == '0);
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, dvsr};
    rem_shift = acc[2*W-1:W-1];
    trial     = rem_shift - {1'b0, dvsr};
    calc_next = acc;
    if (op_q[1]) begin
      if (trial[W])
        calc_next = {rem_shift[W-1:0], acc[W-2:0], 1'b0};
      else
        calc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      if (acc[0])
        calc_next = {mul_sum, acc[W-1:1]};
      else
        calc_next = {1'b0, acc[2*W-1:1]};
    end
  end

  always_comb begin
    prod_neg    = ~acc + 1'b1;
    quo_neg     = ~acc[W-1:0] + 1'b1;
    rem_neg_val = ~acc[2*W-1:W] + 1'b1;
    fix_hi      = acc[2*W-1:W];
    fix_lo      = acc[W-1:0];
    if (op_q[1]) begin
      if (rem_neg) fix_hi = rem_neg_val;
      if (res_neg) fix_lo = quo_neg;
    end else if (res_neg) begin
      fix_hi = prod_neg[2*W-1:W];
      fix_lo = prod_neg[W-1:0];
    end
  end

  // Short paths (divide by zero, zero-skip) enter DONE with done low and spend that first
  // cycle registering their preset result, so results only change once the op cannot be flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      acc       <= '0;
      dvsr      <= '0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      done <= 1'b0;
      if (flush && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !flush) begin
              op_q     <= op;
              cnt      <= CNT_WID'(DATA_WID - 1);
              busy     <= 1'b1;
              div_zero <= 1'b0;
              res_neg  <= a_neg ^ b_neg;
              rem_neg  <= a_neg;
              if (op[1] && b_zero) begin
                acc   <= {srcdata_a, {W{1'b1}}};
                dvsr  <= '0;
                state <= DONE;
              end
`ifdef MULDIV_ZERO_SKIP_EN
              else if (!op[1] && (srcdata_a == '0 || b_zero)) begin
                acc   <= '0;
                dvsr  <= b_mag;
                state <= DONE;
              end
`endif
              else begin
                dvsr  <= op[1] ? b_mag : a_mag;
                acc   <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
                state <= CALC;
              end
            end
          end
          CALC: begin
            acc <= calc_next;
            if (cnt == '0)
              state <= FIXUP;
            else
              cnt <= cnt - 1'b1;
          end
          FIXUP: begin
            result_hi <= fix_hi;
            result_lo <= fix_lo;
            done      <= 1'b1;
            state     <= DONE;
          end
          DONE: begin
            if (!done) begin
              result_hi <= acc[2*W-1:W];
              result_lo <= acc[W-1:0];
              div_zero  <= op_q[1] & (dvsr == '0);
              done      <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: arithmetic results, latency, handshake and
// mid-operation start/flush/reset behaviour, with hand-computed expected values.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] srcdata_a;
  logic [15:0] srcdata_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [15:0] result_hi;
  logic [15:0] result_lo;
  logic        div_zero;

  int tests_run = 0;
  int tests_failed = 0;

  localparam int INJ_NONE  = 0;
  localparam int INJ_START = 1;
  localparam int INJ_FLUSH = 2;
  localparam int INJ_RESET = 3;

  ex_muldiv #(.DATA_WID(16), .CNT_WID(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .srcdata_a (srcdata_a),
    .srcdata_b (srcdata_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the cycle start is held; samples are taken 1 time unit after each rising edge.
  task automatic applyStimulus(input logic [1:0] op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                               input int inj_cyc, input int inj_kind,
                               output int done_cyc, output int busy_cnt, output logic [63:0] busy_trace);
    done_cyc   = -1;
    busy_cnt   = 0;
    busy_trace = '0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = op_v; srcdata_a = a_v; srcdata_b = b_v;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      busy_trace[c] = busy;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (c == inj_cyc) begin
        @(negedge clk);
        if (inj_kind == INJ_START) begin
          start = 1'b1; op = 2'b10; srcdata_a = 16'h0064; srcdata_b = 16'h0000;
        end else if (inj_kind == INJ_FLUSH) begin
          flush = 1'b1;
        end else if (inj_kind == INJ_RESET) begin
          rst = 1'b0;
          #1;
          checkOutput("rst_async_outputs", {29'd0, busy, done, div_zero, result_hi, result_lo}, 64'd0);
          @(negedge clk);
          rst = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
    end
  endtask

  int          dc, bc;
  logic [63:0] bt;
  int          skip_cyc;

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; srcdata_a = '0; srcdata_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_state", {29'd0, busy, done, div_zero, result_hi, result_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(2'b00, 16'hFFFF, 16'hFFFF, 0, INJ_NONE, dc, bc, bt);
    checkOutput("mulu_done_cycle", 64'(dc), 64'd18);
    checkOutput("mulu_busy_cycles", 64'(bc), 64'd18);
    checkOutput("mulu_busy_c1", {63'd0, bt[1]}, 64'd1);
    checkOutput("mulu_result", {32'd0, result_hi, result_lo}, 64'hFFFE0001);
    @(posedge clk); #1;
    checkOutput("mulu_after_done", {62'd0, done, busy}, 64'd0);

    applyStimulus(2'b01, 16'hFFFD, 16'h0005, 0, INJ_NONE, dc, bc, bt);
    checkOutput("mul_signed_result", {32'd0, result_hi, result_lo}, 64'hFFFFFFF1);

    applyStimulus(2'b11, 16'hFFF9, 16'h0002, 0, INJ_NONE, dc, bc, bt);
    checkOutput("div_signed_result", {32'd0, result_hi, result_lo}, 64'hFFFFFFFD);

    applyStimulus(2'b10, 16'h0064, 16'h0000, 0, INJ_NONE, dc, bc, bt);
    checkOutput("divzero_done_cycle", 64'(dc), 64'd2);
    checkOutput("divzero_result", {31'd0, div_zero, result_hi, result_lo}, {31'd0, 1'b1, 32'h0064FFFF});

    applyStimulus(2'b10, 16'h0064, 16'h0007, 0, INJ_NONE, dc, bc, bt);
    checkOutput("divu_done_cycle", 64'(dc), 64'd18);
    checkOutput("divu_result", {31'd0, div_zero, result_hi, result_lo}, {31'd0, 1'b0, 32'h0002000E});

    applyStimulus(2'b11, 16'h8000, 16'hFFFF, 0, INJ_NONE, dc, bc, bt);
    checkOutput("div_overflow", {31'd0, div_zero, result_hi, result_lo}, {31'd0, 1'b0, 32'h00008000});

    applyStimulus(2'b00, 16'h0003, 16'h0004, 5, INJ_START, dc, bc, bt);
    checkOutput("ignore_start_cycle", 64'(dc), 64'd18);
    checkOutput("ignore_start_result", {31'd0, div_zero, result_hi, result_lo}, {31'd0, 1'b0, 32'h0000000C});

    applyStimulus(2'b00, 16'h1111, 16'h2222, 7, INJ_FLUSH, dc, bc, bt);
    checkOutput("flush_no_done", 64'(dc), -64'sd1);
    checkOutput("flush_busy_c7_c8", {62'd0, bt[7], bt[8]}, 64'b10);
    checkOutput("flush_results_kept", {32'd0, result_hi, result_lo}, 64'h0000000C);

    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; srcdata_a = 16'h0002; srcdata_b = 16'h0002;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_beats_start", {63'd0, busy}, 64'd0);

    applyStimulus(2'b00, 16'hFFFF, 16'hFFFF, 9, INJ_RESET, dc, bc, bt);
    checkOutput("reset_no_done", 64'(dc), -64'sd1);

`ifdef MULDIV_ZERO_SKIP_EN
    skip_cyc = 2;
`else
    skip_cyc = 18;
`endif
    applyStimulus(2'b00, 16'h0000, 16'h1234, 0, INJ_NONE, dc, bc, bt);
    checkOutput("zero_mul_cycle", 64'(dc), 64'(skip_cyc));
    checkOutput("zero_mul_result", {32'd0, result_hi, result_lo}, 64'h0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
